// File: rtl/mux2ne1_16b.sv
// Two-input word selector: a combinational output for same-cycle datapath use
// plus an enable-captured registered copy with a valid flag.
`timescale 1ns/1ps

module mux2ne1_16b #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Hyrja0,
    input  logic [WIDTH-1:0] Hyrja1,
    input  logic             S,
    input  logic             En,
    output logic [WIDTH-1:0] Dalja,
    output logic [WIDTH-1:0] DaljaReg,
    output logic             Valid
);

    // Unknown select yields an unknown word rather than favouring either input.
    always_comb begin
        Dalja = '0;
        case (S)
            1'b0:    Dalja = Hyrja0;
            1'b1:    Dalja = Hyrja1;
            default: Dalja = 'x;
        endcase
    end

    // Valid is a sticky flag rather than a handshake: it rises on the first
    // enabled capture after reset and stays high until the next reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            DaljaReg <= RESET_VALUE;
            Valid    <= 1'b0;
        end else if (En) begin
            DaljaReg <= Dalja;
            Valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux2ne1_16b.sv
// Self-checking bench for mux2ne1_16b: directed scenarios followed by random
// traffic, all checked against a behavioural model of select/capture/reset.
`timescale 1ns/1ps

module tb_mux2ne1_16b;

    localparam int               WIDTH       = 16;
    localparam logic [WIDTH-1:0] RESET_VALUE = '0;

    logic             Clock;
    logic             Reset_n;
    logic [WIDTH-1:0] Hyrja0;
    logic [WIDTH-1:0] Hyrja1;
    logic             S;
    logic             En;
    logic [WIDTH-1:0] Dalja;
    logic [WIDTH-1:0] DaljaReg;
    logic             Valid;

    int tests_run = 0;
    int tests_failed = 0;

    // model state: the word the register should hold and whether one was captured
    logic [WIDTH-1:0] exp_reg;
    logic             exp_valid;

    mux2ne1_16b #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Hyrja0   (Hyrja0),
        .Hyrja1   (Hyrja1),
        .S        (S),
        .En       (En),
        .Dalja    (Dalja),
        .DaljaReg (DaljaReg),
        .Valid    (Valid)
    );

    // clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH-1:0] pick(input logic sel, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return sel ? b : a;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dalja"}, Dalja, pick(S, Hyrja0, Hyrja1));
        check({tag, "_reg"}, DaljaReg, exp_reg);
        check({tag, "_valid"}, {{(WIDTH-1){1'b0}}, Valid}, {{(WIDTH-1){1'b0}}, exp_valid});
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sel, input logic en);
        Hyrja0 = a;
        Hyrja1 = b;
        S      = sel;
        En     = en;
    endtask

    // One rising edge; the model captures what was driven before it.
    task automatic tick(input string tag);
        if (En) begin
            exp_reg   = pick(S, Hyrja0, Hyrja1);
            exp_valid = 1'b1;
        end
        @(posedge Clock);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
    task automatic reset_pulse(input string tag);
        #1;
        Reset_n   = 1'b0;
        exp_reg   = RESET_VALUE;
        exp_valid = 1'b0;
        #1;
        check_all(tag);
        Reset_n = 1'b1;
        #1;
        check_all({tag, "_rel"});
    endtask

    initial begin
        logic [WIDTH-1:0] prev;

        // reset with no clock edge
        Reset_n   = 1'b0;
        exp_reg   = RESET_VALUE;
        exp_valid = 1'b0;
        drive(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        #1;
        check_all("rst_async");
        Reset_n = 1'b1;
        #1;
        check_all("rst_release_noedge");

        // pure combinational selection before any clock edge
        drive(16'd5, 16'd20, 1'b0, 1'b0);
        #1;
        check("comb_s0", Dalja, 16'd5);
        S = 1'b1;
        #0.5;
        check("comb_s1", Dalja, 16'd20);

        // first enabled capture
        drive(16'h1234, 16'hABCD, 1'b1, 1'b1);
        tick("cap_first");
        check("cap_first_lit", DaljaReg, 16'hABCD);

        // hold with En=0 while inputs move
        drive(16'h1234, 16'hABCD, 1'b0, 1'b0);
        tick("hold0");
        Hyrja1 = 16'h5555;
        tick("hold1");
        Hyrja1 = 16'h0F0F;
        S      = 1'b1;
        tick("hold2");
        check("hold_lit", DaljaReg, 16'hABCD);

        // alternating select, register trails the comb output by one cycle
        for (int i = 0; i < 4; i++) begin
            drive(16'h0000, 16'hFFFF, i[0], 1'b1);
            #1;
            prev = Dalja;
            tick("alt");
            check("alt_lag", DaljaReg, prev);
        end

        // mid-operation reset discards the held word; next edge recaptures
        reset_pulse("rst_mid");
        drive(16'h2468, 16'h1357, 1'b0, 1'b1);
        tick("recap");

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            #1;
            check("rnd_comb", Dalja, pick(S, Hyrja0, Hyrja1));
            tick("rnd");
            if ($urandom_range(0, 15) == 0) reset_pulse("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
